// File: rtl/md_unit_pkg.sv
// Shared multiply/divide opcodes and decode helpers used by md_unit, md_core and the bench.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MADDU = 4'd6,
    MD_MSUB  = 4'd7,
    MD_MSUBU = 4'd8,
    MD_MTHI  = 4'd9,
    MD_MTLO  = 4'd10
  } md_op_e;

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_multi_cycle(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MSUBU);
  endfunction

  function automatic logic is_move(input logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational HI/LO result for every MD opcode, including all divide corner cases.
module md_core
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] HI,
  input  logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic signed [W2-1:0]    a_sx, b_sx, prod_s;
  logic [W2-1:0]           prod_u, acc, res;
  logic signed [WIDTH-1:0] a_s, b_s, quo_s, rem_s;
  logic                    div_zero, div_ovf;

  assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign acc    = {HI, LO};

  assign a_s      = A;
  assign b_s      = B;
  assign quo_s    = a_s / b_s;
  assign rem_s    = a_s % b_s;
  assign div_zero = (B == '0);
  // MIN_INT / -1 overflows the quotient; pin it to MIN_INT with zero remainder.
  assign div_ovf  = (A == MIN_INT) && (B == ALL_ONES);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    res = acc;
    case (md_op)
      MD_MULT:  res = $unsigned(prod_s);
      MD_MULTU: res = prod_u;
      MD_MADD:  res = acc + $unsigned(prod_s);
      MD_MADDU: res = acc + prod_u;
      MD_MSUB:  res = acc - $unsigned(prod_s);
      MD_MSUBU: res = acc - prod_u;
      MD_DIV: begin
        if (div_zero)     res = {A, ALL_ONES};
        else if (div_ovf) res = {{WIDTH{1'b0}}, MIN_INT};
        else              res = {rem_s, quo_s};
      end
      MD_DIVU: begin
        if (div_zero) res = {A, ALL_ONES};
        else          res = {A % B, A / B};
      end
      MD_MTHI:  res = {A, LO};
      MD_MTLO:  res = {HI, A};
      default:  res = acc;
    endcase
  end

  assign {hi_next, lo_next} = res;

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: owns busy, the latency counter, the pending result and the HI/LO registers.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     pend_q, pend_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]       core_hi, core_lo;

  md_core #(.WIDTH(WIDTH)) u_core (
    .md_op   (md_op),
    .A       (A),
    .B       (B),
    .HI      (hi_q),
    .LO      (lo_q),
    .hi_next (core_hi),
    .lo_next (core_lo)
  );

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d       = 1'b0;
        {hi_d, lo_d} = pend_q;
      end
    end else if (start) begin
      // Result is captured at accept, so A/B may change freely while busy.
      if (is_multi_cycle(md_op)) begin
        busy_d = 1'b1;
        pend_d = {core_hi, core_lo};
        cnt_d  = is_div(md_op) ? DIV_N : MULT_N;
      end else if (is_move(md_op)) begin
        {hi_d, lo_d} = {core_hi, core_lo};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      // NOTE: the pending register is reset too, so an aborted operation can never leak into HI/LO.
      pend_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: reference model feeds a scoreboard queue checked at each commit.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = MD_NONE;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
    longint      sa, sb;
    logic [63:0] ps, pu, acc;
    logic [31:0] ma, mb, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = sa * sb;
    pu  = {32'h0, a} * {32'h0, b};
    acc = {hi, lo};
    case (op)
      MD_MULT:  return ps;
      MD_MULTU: return pu;
      MD_MADD:  return acc + ps;
      MD_MADDU: return acc + pu;
      MD_MSUB:  return acc - ps;
      MD_MSUBU: return acc - pu;
      MD_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31]) r = ~r + 32'd1;
        return {r, q};
      end
      MD_MTHI:  return {a, lo};
      MD_MTLO:  return {hi, a};
      default:  return acc;
    endcase
  endfunction

  // Caller must be at a negedge; returns at the first negedge with busy low after commit.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, input string name, input bit inject);
    logic [63:0] old, exp;
    int          exp_cyc, cyc;
    exp_cyc = (op == MD_DIV || op == MD_DIVU) ? DC :
              (op >= MD_MULT && op <= MD_MSUBU) ? MC : 0;
    old = {m_hi, m_lo};
    exp = ref_op(op, a, b, m_hi, m_lo);
    sb_q.push_back(exp);
    {m_hi, m_lo} = exp;
    md_op = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE; A = $urandom; B = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      n_cmp++;
      if ({HI, LO} !== old) begin
        n_err++;
        $display("FAIL %s hold: got %h expected %h", name, {HI, LO}, old);
      end
      if (inject && cyc == 2) begin
        start = 1'b1; md_op = MD_MULT; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (cyc != exp_cyc) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_cyc);
    end
    exp = sb_q.pop_front();
    n_cmp++;
    if ({HI, LO} !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h expected %h", name, {HI, LO}, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, HI, LO} !== 65'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", {busy, HI, LO}, 65'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, "mult", 1'b0);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, "multu", 1'b0);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, "mult_min", 1'b0);
  endtask

  task automatic test_div();
    run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0);
    run_op(MD_DIVU, 32'd7, 32'd0, "divu_zero", 1'b0);
    run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    run_op(MD_DIV,  32'd7, 32'hFFFF_FFFE, "div_pos_neg", 1'b0);
    run_op(MD_DIV,  32'hFFFF_FFF9, 32'd0, "div_zero", 1'b0);
    run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, "divu", 1'b0);
  endtask

  task automatic test_move();
    run_op(MD_MTLO, 32'd5, 32'd0, "mtlo", 1'b0);
    run_op(MD_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi", 1'b0);
    run_op(4'd13, 32'h1234_5678, 32'h9, "illegal", 1'b0);
    run_op(MD_NONE, 32'h1234_5678, 32'h9, "none", 1'b0);
  endtask

  task automatic test_madd();
    run_op(MD_MTHI,  32'd1, 32'd0, "madd_mthi", 1'b0);
    run_op(MD_MTLO,  32'd0, 32'd0, "madd_mtlo", 1'b0);
    run_op(MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu", 1'b0);
    run_op(MD_MSUB,  32'd1, 32'd1, "msub", 1'b0);
    run_op(MD_MADD,  32'hFFFF_FFFF, 32'd3, "madd", 1'b0);
    run_op(MD_MSUBU, 32'hFFFF_FFFF, 32'd2, "msubu", 1'b0);
  endtask

  task automatic test_busy_start();
    run_op(MD_DIV,  32'd1000, 32'd7, "div_inject", 1'b1);
    run_op(MD_MULT, 32'd12, 32'hFFFF_FFF0, "mult_inject", 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [8];
    logic [31:0] a, b;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MSUBU, MD_MTHI, MD_MTLO};
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op(ops[$urandom_range(0, 7)], a, b, "b2b", 1'b0);
    end
  endtask

  task automatic test_reset_abort();
    run_op(MD_MTHI, 32'd9, 32'd0, "abort_mthi", 1'b0);
    run_op(MD_MTLO, 32'd9, 32'd0, "abort_mtlo", 1'b0);
    md_op = MD_DIV; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, HI, LO} !== 65'h0) begin
      n_err++;
      $display("FAIL abort_async: got %h expected %h", {busy, HI, LO}, 65'h0);
    end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 2) @(negedge clk);
    n_cmp++;
    if ({busy, HI, LO} !== 65'h0) begin
      n_err++;
      $display("FAIL abort_no_commit: got %h expected %h", {busy, HI, LO}, 65'h0);
    end
    run_op(MD_MULTU, 32'd6, 32'd7, "after_abort", 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_madd();
    test_busy_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
